fpu_lane_dispatcher: RTL
========================

FPU_LANE_DISPATCHER -- requirements
Module: fpu_lane_dispatcher

Interface
REQ-001 Parameters SHALL be:
- FLEN, 64, operand/result width.
- NUM_LANES, 2, number of external pipelined FP units (1..8).
- ROB_DEPTH, 8, reorder-buffer slots (power of 2, 2..64).
- OP_WIDTH, 4, opaque opcode width.
- Derived TAG_W = log2(ROB_DEPTH)+1; the MSB is the epoch bit.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- rst_i, in, 1, asynchronous active-high reset.
- req_valid_i / req_ready_o, in / out, 1 / 1, request handshake.
- req_operands_i, in, 3*FLEN, three operands.
- req_op_i, in, OP_WIDTH, opcode.
- req_rnd_i, in, 3, rounding mode.
- flush_i, in, 1, discard all in-flight work.
- resp_valid_o / resp_ready_i, out / in, 1 / 1, response handshake.
- resp_result_o, out, FLEN, result.
- resp_status_o, out, 5, exception flags.
- busy_o, out, 1, ROB non-empty.
- lane_in_valid_o / lane_in_ready_i, out / in, NUM_LANES each, per-lane issue handshake.
- lane_operands_o, out, 3*FLEN, shared issue operands.
- lane_op_o, out, OP_WIDTH, shared issue opcode.
- lane_rnd_o, out, 3, shared issue rounding mode.
- lane_tag_o, out, TAG_W, shared issue tag.
- lane_out_valid_i, in, NUM_LANES, per-lane result valid.
- lane_out_ready_o, out, NUM_LANES, per-lane result ready.
- lane_result_i, in, NUM_LANES*FLEN, per-lane results.
- lane_status_i, in, NUM_LANES*5, per-lane flags.
- lane_tag_i, in, NUM_LANES*TAG_W, per-lane returned tags.

REQ-003 Reset SHALL be asynchronous and active-high on rst_i, with a single clock clk_i.

Function
REQ-004 req_ready_o SHALL equal: not full, AND at least one lane_in_ready_i high, AND not flush_i, AND not rst_i.
REQ-005 Accepted requests SHALL be issued the same cycle, combinationally, to exactly one lane.
- That lane is the first ready lane at or after the round-robin pointer rr.
- rr then becomes granted+1 mod NUM_LANES.
REQ-006 The issue tag SHALL be {epoch, tail}. On accept, slot[tail] is cleared to not-done, tail increments modulo ROB_DEPTH, and count increments.
REQ-007 lane_out_ready_o SHALL be all-ones. A returned result SHALL be written to slot[tag index] and marked done only if the tag epoch equals the current epoch; otherwise it is silently dropped.
- Multiple lanes returning in the same cycle SHALL all be written.
REQ-008 Response outputs SHALL be driven from the head slot.
- resp_valid_o = count>0 AND done[head].
- On resp_valid_o && resp_ready_i: head increments modulo ROB_DEPTH and count decrements.
- Responses SHALL leave strictly in acceptance order.
REQ-009 Accept and retire in the same cycle SHALL leave count unchanged. Full is count==ROB_DEPTH; empty is count==0. Pointers wrap without loss.
REQ-010 Minimum latency SHALL be lane latency + 1 cycle, because the ROB write is registered before resp_valid_o rises.
REQ-011 flush_i SHALL act on the next edge:
- head, tail and count are zeroed and all done bits cleared.
- The epoch toggles.
- resp_valid_o is low the cycle after the flush edge.
REQ-012 busy_o SHALL equal count!=0.
REQ-013 resp_result_o and resp_status_o are don't-care while resp_valid_o is low.

Reset
REQ-014 On reset, head, tail, count, rr and epoch SHALL be 0 and all done bits cleared.
- While rst_i is asserted: resp_valid_o=0, req_ready_o=0, busy_o=0, lane_in_valid_o=0.
REQ-015 Reset asserted mid-operation SHALL abandon all in-flight entries.
- Results arriving after reset release whose tag epoch is 0 SHALL be treated as live. Lanes SHALL therefore share the dispatcher reset.

Configuration
REQ-016 The macro FPU_DISPATCH_STATS_EN SHALL control the statistics counters.
- Defined: adds output ports stat_issued_o (32 bits, counts accepted requests) and stat_full_stall_o (32 bits, counts cycles with req_valid_i high and req_ready_o low).
- Both counters saturate at all-ones, reset to 0, and are not cleared by flush_i.
- Not defined: these ports and counters are absent and all other behaviour is identical.

Verification
REQ-017 Single op: one request, lane 0 with latency 3 -> resp_valid_o rises 4 cycles after accept with lane 0's result and status.
REQ-018 Out-of-order return: two requests issued to lanes 0 and 1, lane 1 returns 5 cycles earlier -> responses emerge in order (tag 0, then tag 1).
REQ-019 Full: ROB_DEPTH=8, resp_ready_i=0, 9 back-to-back requests -> 8 accepted, then req_ready_o=0 with busy_o=1; one retire -> the ninth is accepted the next cycle.
REQ-020 Wrap: 20 sequential requests with random lane latencies and random resp_ready_i -> 20 in-order responses; tail wraps twice.
REQ-021 Flush: flush_i with 3 in flight, then the old tags return -> no response produced, epoch=1, and a new request returns tag {1,0}.
REQ-022 Round-robin with all lanes ready and 4 back-to-back requests, NUM_LANES=2 -> grants alternate 0,1,0,1. With the macro defined -> stat_issued_o=4.

Source files
------------

// File: rtl/fpu_lane_dispatcher.sv
// ============================================================================
// fpu_lane_dispatcher
// ----------------------------------------------------------------------------
// Dispatches floating-point requests onto NUM_LANES external pipelined FP
// units and returns their results strictly in acceptance order through a
// reorder buffer (ROB) of ROB_DEPTH slots.
//
// Each accepted request is issued combinationally, in the same cycle, to the
// first ready lane at or after a round-robin pointer. The request carries the
// tag {epoch, tail}. Lanes return {result, status, tag} in any order. A
// returned result is written into its ROB slot only if the tag epoch matches
// the current epoch, so work in flight across a flush is silently dropped.
// Responses are always presented from the head slot.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   req_valid_i / req_ready_o  request handshake
//   req_operands_i             three FLEN-bit operands
//   req_op_i, req_rnd_i        opaque opcode, rounding mode
//   flush_i                    discard all in-flight work on the next edge
//   resp_valid_o / resp_ready_i response handshake
//   resp_result_o, resp_status_o head-slot result and exception flags
//   busy_o                     ROB non-empty
//   lane_in_valid_o / lane_in_ready_i  per-lane issue handshake
//   lane_operands_o, lane_op_o, lane_rnd_o, lane_tag_o  shared issue bus
//   lane_out_valid_i / lane_out_ready_o per-lane result handshake
//   lane_result_i, lane_status_i, lane_tag_i            per-lane returns
//
// Optional feature (macro FPU_DISPATCH_STATS_EN):
//   stat_issued_o      saturating count of accepted requests
//   stat_full_stall_o  saturating count of cycles with req_valid_i high and
//                      req_ready_o low
//   Both reset to 0 and survive flush_i.
// ============================================================================
module fpu_lane_dispatcher #(
    parameter  int unsigned FLEN      = 64,
    parameter  int unsigned NUM_LANES = 2,
    parameter  int unsigned ROB_DEPTH = 8,
    parameter  int unsigned OP_WIDTH  = 4,
    localparam int unsigned IDX_W     = $clog2(ROB_DEPTH),
    localparam int unsigned TAG_W     = IDX_W + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [3*FLEN-1:0]          req_operands_i,
    input  logic [OP_WIDTH-1:0]        req_op_i,
    input  logic [2:0]                 req_rnd_i,

    input  logic                       flush_i,

    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [FLEN-1:0]            resp_result_o,
    output logic [4:0]                 resp_status_o,

    output logic                       busy_o,

    output logic [NUM_LANES-1:0]       lane_in_valid_o,
    input  logic [NUM_LANES-1:0]       lane_in_ready_i,
    output logic [3*FLEN-1:0]          lane_operands_o,
    output logic [OP_WIDTH-1:0]        lane_op_o,
    output logic [2:0]                 lane_rnd_o,
    output logic [TAG_W-1:0]           lane_tag_o,

    input  logic [NUM_LANES-1:0]       lane_out_valid_i,
    output logic [NUM_LANES-1:0]       lane_out_ready_o,
    input  logic [NUM_LANES*FLEN-1:0]  lane_result_i,
    input  logic [NUM_LANES*5-1:0]     lane_status_i,
    input  logic [NUM_LANES*TAG_W-1:0] lane_tag_i
`ifdef FPU_DISPATCH_STATS_EN
    ,
    output logic [31:0]                stat_issued_o,
    output logic [31:0]                stat_full_stall_o
`endif
);

    localparam int unsigned RR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]     head;
    logic [IDX_W-1:0]     tail;
    logic [TAG_W-1:0]     count;
    logic [RR_W-1:0]      rr;
    logic                 epoch;
    logic [ROB_DEPTH-1:0] done;

    logic [FLEN-1:0]      res_mem [ROB_DEPTH];
    logic [4:0]           st_mem  [ROB_DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                 full;
    logic                 grant_found;
    logic [RR_W-1:0]      grant_idx;
    logic [RR_W-1:0]      cand;
    logic [RR_W-1:0]      rr_next;
    logic                 accept;
    logic                 retire;
    logic [NUM_LANES-1:0] ret_live;
    logic [IDX_W-1:0]     ret_idx [NUM_LANES];

    // Wraps a lane number in [0, 2*NUM_LANES) back into [0, NUM_LANES);
    // NUM_LANES need not be a power of two.
    function automatic logic [RR_W-1:0] lane_wrap(input int unsigned v);
        int unsigned w;
        w = (v >= NUM_LANES) ? v - NUM_LANES : v;
        return RR_W'(w);
    endfunction

    assign full = (count == TAG_W'(ROB_DEPTH));

    // First ready lane at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cand = lane_wrap(32'(rr) + i);
            if (!grant_found && lane_in_ready_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign rr_next     = lane_wrap(32'(grant_idx) + 32'd1);
    assign req_ready_o = !full && grant_found && !flush_i && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        lane_in_valid_o = '0;
        if (accept) begin
            lane_in_valid_o[grant_idx] = 1'b1;
        end
    end

    assign lane_operands_o  = req_operands_i;
    assign lane_op_o        = req_op_i;
    assign lane_rnd_o       = req_rnd_i;
    assign lane_tag_o       = {epoch, tail};
    assign lane_out_ready_o = '1;

    // A returned result is live only if its epoch bit matches ours; stale
    // results from before a flush are dropped here.
    always_comb begin
        ret_live = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            ret_idx[l]  = lane_tag_i[l*TAG_W +: IDX_W];
            ret_live[l] = lane_out_valid_i[l] && (lane_tag_i[l*TAG_W + IDX_W] == epoch);
        end
    end

    assign resp_valid_o  = (count != '0) && done[head];
    assign retire        = resp_valid_o && resp_ready_i;
    assign resp_result_o = res_mem[head];
    assign resp_status_o = st_mem[head];
    assign busy_o        = (count != '0);

    // ------------------------------------------------------------------
    // ROB pointers, done bits, epoch, round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rr    <= '0;
            epoch <= 1'b0;
            done  <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
            epoch <= ~epoch;
        end else begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                if (ret_live[l]) begin
                    done[ret_idx[l]] <= 1'b1;
                end
            end
            // Allocation is written after the returns so a fresh slot is
            // always not-done, whatever else targets it this cycle.
            if (accept) begin
                done[tail] <= 1'b0;
                tail       <= tail + IDX_W'(1);
                rr         <= rr_next;
            end
            if (retire) begin
                head <= head + IDX_W'(1);
            end
            if (accept && !retire) begin
                count <= count + TAG_W'(1);
            end else if (!accept && retire) begin
                count <= count - TAG_W'(1);
            end
        end
    end

    // Result storage needs no reset: a slot is only read once its done bit
    // is set.
    always_ff @(posedge clk_i) begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (ret_live[l]) begin
                res_mem[ret_idx[l]] <= lane_result_i[l*FLEN +: FLEN];
                st_mem[ret_idx[l]]  <= lane_status_i[l*5 +: 5];
            end
        end
    end

`ifdef FPU_DISPATCH_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics; intentionally untouched by flush_i.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_issued_o     <= '0;
            stat_full_stall_o <= '0;
        end else begin
            if (accept && (stat_issued_o != '1)) begin
                stat_issued_o <= stat_issued_o + 32'd1;
            end
            if (req_valid_i && !req_ready_o && (stat_full_stall_o != '1)) begin
                stat_full_stall_o <= stat_full_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule
